// File: rtl/cam_lookup_ctrl.sv
// Lookup/allocate controller in front of a DEPTH-entry CAM.
// Define CAM_LOOKUP_STATS_EN to add saturating hit/miss/evict counters.
module cam_lookup_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int CAM_LAT    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_key_i,
    input  logic                  req_alloc_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic                  rsp_new_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic                  cam_search_o,
    output logic [DATA_WIDTH-1:0] cam_search_data_o,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
    output logic                  cam_write_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [DATA_WIDTH-1:0] cam_write_data_o,
`ifdef CAM_LOOKUP_STATS_EN
    output logic [15:0]           hit_cnt_o,
    output logic [15:0]           miss_cnt_o,
    output logic [15:0]           evict_cnt_o,
`endif
    output logic                  full_o
);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        WAIT,
        ALLOC,
        RESP
    } state_t;

    localparam logic [2:0]          LAT  = 3'(CAM_LAT);
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [DATA_WIDTH-1:0]   key;
    logic                    alloc;
    logic [2:0]              wait_cnt;
    logic [ADDR_WIDTH:0]     fill;
    logic [ADDR_WIDTH-1:0]   victim;
    logic [ADDR_WIDTH-1:0]   slot;
    logic                    full;
    logic                    sample;

    // Cycle in which the CAM result lines are valid.
    assign sample = (state == WAIT) && (wait_cnt == 3'd1);
    assign slot   = full ? victim : fill[ADDR_WIDTH-1:0];

    assign cam_search_data_o = key;
    assign cam_write_data_o  = key;
    assign cam_write_index_o = slot;
    assign full_o            = full;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        req_ready_o  = 1'b0;
        cam_search_o = 1'b0;
        cam_write_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_o = ~rst_i;
                if (req_valid_i) state_nx = SEARCH;
            end
            SEARCH: begin
                cam_search_o = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (sample) begin
                    if (!cam_search_valid_i && alloc) state_nx = ALLOC;
                    else                              state_nx = RESP;
                end
            end
            ALLOC: begin
                cam_write_o = 1'b1;
                state_nx    = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key         <= '0;
            alloc       <= 1'b0;
            wait_cnt    <= '0;
            fill        <= '0;
            victim      <= '0;
            full        <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_new_o   <= 1'b0;
            rsp_index_o <= '0;
`ifdef CAM_LOOKUP_STATS_EN
            hit_cnt_o   <= '0;
            miss_cnt_o  <= '0;
            evict_cnt_o <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        key   <= req_key_i;
                        alloc <= req_alloc_i;
                    end
                end
                SEARCH: wait_cnt <= LAT;
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (sample && cam_search_valid_i) begin
                        rsp_hit_o   <= 1'b1;
                        rsp_new_o   <= 1'b0;
                        rsp_index_o <= cam_search_index_i;
`ifdef CAM_LOOKUP_STATS_EN
                        if (hit_cnt_o != 16'hFFFF) hit_cnt_o <= hit_cnt_o + 16'd1;
`endif
                    end else if (sample && !alloc) begin
                        rsp_hit_o   <= 1'b0;
                        rsp_new_o   <= 1'b0;
                        rsp_index_o <= '0;
`ifdef CAM_LOOKUP_STATS_EN
                        if (miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
`endif
                    end
                end
                ALLOC: begin
                    rsp_hit_o   <= 1'b0;
                    rsp_new_o   <= 1'b1;
                    rsp_index_o <= slot;
                    // Filling and first eviction never share a cycle.
                    if (!full) begin
                        fill <= fill + (ADDR_WIDTH+1)'(1);
                        if (fill == LAST) full <= 1'b1;
                    end else begin
                        victim <= victim + ADDR_WIDTH'(1);
                    end
`ifdef CAM_LOOKUP_STATS_EN
                    if (miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
                    if (full && evict_cnt_o != 16'hFFFF) evict_cnt_o <= evict_cnt_o + 16'd1;
`endif
                end
                RESP: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Bench for cam_lookup_ctrl: CAM environment model plus a table-level
// reference of hit/allocate/evict rules, directed and random lookups.
module tb_cam_lookup_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int LAT   = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready_o;
    logic [DW-1:0] req_key;
    logic          req_alloc;
    logic          rsp_valid_o;
    logic          rsp_ready;
    logic          rsp_hit_o;
    logic          rsp_new_o;
    logic [AW-1:0] rsp_index_o;
    logic          cam_search_o;
    logic [DW-1:0] cam_search_data_o;
    logic          cam_search_valid_i;
    logic [AW-1:0] cam_search_index_i;
    logic          cam_write_o;
    logic [AW-1:0] cam_write_index_o;
    logic [DW-1:0] cam_write_data_o;
    logic          full_o;
`ifdef CAM_LOOKUP_STATS_EN
    logic [15:0]   hit_cnt_o;
    logic [15:0]   miss_cnt_o;
    logic [15:0]   evict_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cam_lookup_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .CAM_LAT(LAT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready_o),
        .req_key_i(req_key),
        .req_alloc_i(req_alloc),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready),
        .rsp_hit_o(rsp_hit_o),
        .rsp_new_o(rsp_new_o),
        .rsp_index_o(rsp_index_o),
        .cam_search_o(cam_search_o),
        .cam_search_data_o(cam_search_data_o),
        .cam_search_valid_i(cam_search_valid_i),
        .cam_search_index_i(cam_search_index_i),
        .cam_write_o(cam_write_o),
        .cam_write_index_o(cam_write_index_o),
        .cam_write_data_o(cam_write_data_o),
`ifdef CAM_LOOKUP_STATS_EN
        .hit_cnt_o(hit_cnt_o),
        .miss_cnt_o(miss_cnt_o),
        .evict_cnt_o(evict_cnt_o),
`endif
        .full_o(full_o)
    );

    // CAM environment: result after LAT cycles, random junk otherwise.
    logic [DW-1:0] mem_key [DEPTH];
    logic          mem_v   [DEPTH];
    logic          ph      [8];
    logic          pv      [8];
    logic [AW-1:0] pi      [8];
    logic          junk_v;
    logic [AW-1:0] junk_i;
    int            wr_cnt = 0;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] wr_data;

    assign cam_search_valid_i = ph[LAT-1] ? pv[LAT-1] : junk_v;
    assign cam_search_index_i = ph[LAT-1] ? pi[LAT-1] : junk_i;

    always @(posedge clk) begin
        for (int i = 7; i > 0; i--) begin
            ph[i] <= ph[i-1];
            pv[i] <= pv[i-1];
            pi[i] <= pi[i-1];
        end
        ph[0] <= cam_search_o && !rst;
        pv[0] <= 1'b0;
        pi[0] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cam_search_o && mem_v[i] === 1'b1 && mem_key[i] == cam_search_data_o) begin
                pv[0] <= 1'b1;
                pi[0] <= AW'(i);
            end
        end
        junk_v <= 1'($urandom);
        junk_i <= AW'($urandom);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_v[i] <= 1'b0;
            for (int i = 1; i < 8; i++) ph[i] <= 1'b0;
        end else if (cam_write_o) begin
            mem_key[cam_write_index_o] <= cam_write_data_o;
            mem_v[cam_write_index_o]   <= 1'b1;
            wr_cnt  <= wr_cnt + 1;
            wr_idx  <= cam_write_index_o;
            wr_data <= cam_write_data_o;
        end
    end

    // Reference: key -> slot map, fill count, victim pointer.
    int            ref_map [logic [DW-1:0]];
    logic [DW-1:0] ref_owner [DEPTH];
    int            ref_fill = 0;
    int            ref_victim = 0;
    int            ref_hits = 0;
    int            ref_miss = 0;
    int            ref_evict = 0;

    task automatic predict(input logic [DW-1:0] key, input logic alloc,
                           output logic hit, output logic nw, output logic [AW-1:0] idx);
        hit = 1'b0;
        nw  = 1'b0;
        idx = '0;
        if (ref_map.exists(key)) begin
            hit = 1'b1;
            idx = AW'(ref_map[key]);
            ref_hits++;
        end else begin
            ref_miss++;
            if (alloc) begin
                nw = 1'b1;
                if (ref_fill < DEPTH) begin
                    idx = AW'(ref_fill);
                    ref_fill++;
                end else begin
                    idx = AW'(ref_victim);
                    ref_victim = (ref_victim + 1) % DEPTH;
                    ref_evict++;
                    ref_map.delete(ref_owner[idx]);
                end
                ref_owner[idx] = key;
                ref_map[key]   = int'(idx);
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef CAM_LOOKUP_STATS_EN
        check("hit_cnt", 64'(hit_cnt_o), 64'(ref_hits));
        check("miss_cnt", 64'(miss_cnt_o), 64'(ref_miss));
        check("evict_cnt", 64'(evict_cnt_o), 64'(ref_evict));
`endif
    endtask

    task automatic lookup(input logic [DW-1:0] key, input logic alloc, input int hold);
        logic          eh;
        logic          en;
        logic [AW-1:0] ei;
        int            lat;
        int            w0;
        bit            got;
        predict(key, alloc, eh, en, ei);
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = key;
        req_alloc = alloc;
        rsp_ready = (hold == 0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 64'(got), 64'd1);
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check("rsp_seen", 64'(got), 64'd1);
        check("latency", 64'(lat), 64'(LAT + 2 + int'(en)));
        check("rsp_fields", {61'd0, rsp_hit_o, rsp_new_o, 1'b0} | 64'(rsp_index_o) << 8,
              {61'd0, eh, en, 1'b0} | 64'(ei) << 8);
        check("write_count", 64'(wr_cnt - w0), 64'(int'(en)));
        if (en) check("write_slot", {27'd0, wr_idx, wr_data}, {27'd0, ei, key});
        check("full", 64'(full_o), 64'(ref_fill == DEPTH));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", 64'({rsp_valid_o, req_ready_o, rsp_hit_o, rsp_new_o, rsp_index_o}),
                  64'({1'b1, 1'b0, eh, en, ei}));
        end
        if (hold > 0) begin
            @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("back_idle", 64'({rsp_valid_o, req_ready_o}), 64'd1);
    endtask

    initial begin
        int w0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_key   = '0;
        req_alloc = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 64'({req_ready_o, rsp_valid_o, rsp_hit_o, rsp_new_o,
              cam_search_o, cam_write_o, full_o, rsp_index_o, cam_write_index_o}), 64'd0);
        check("reset_data", {cam_search_data_o, cam_write_data_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(req_ready_o), 64'd1);
        check_stats();

        lookup(32'hDEADBEEF, 1'b1, 0);
        lookup(32'hDEADBEEF, 1'b0, 0);
        lookup(32'h00000001, 1'b0, 0);
        for (int i = 1; i < DEPTH; i++) lookup(32'hA0000000 + DW'(i), 1'b1, 0);
        lookup(32'hA0000100, 1'b1, 0);
        lookup(32'hA0000101, 1'b1, 0);
        lookup(32'hA0000100, 1'b1, 0);
        check_stats();

        for (int n = 0; n < 40; n++) begin
            lookup(32'h50000000 | DW'($urandom_range(0, 40)),
                   1'($urandom_range(0, 1)), 0);
        end
        check_stats();

        lookup(32'hA0000100, 1'b0, 10);
        lookup(32'h77777777, 1'b1, 10);
        check_stats();

        // Abort an allocating miss in WAIT with an async reset.
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = 32'hCAFE0001;
        req_alloc = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_outs", 64'({req_ready_o, rsp_valid_o, rsp_hit_o, rsp_new_o,
              cam_search_o, cam_write_o, full_o, rsp_index_o, cam_write_index_o}), 64'd0);
        check("async_reset_data", {cam_search_data_o, cam_write_data_o}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        w0  = wr_cnt;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("no_write_after_reset", 64'(wr_cnt - w0), 64'd0);
        check("idle_after_reset", 64'({req_ready_o, rsp_valid_o}), 64'd2);
        ref_map.delete();
        ref_fill   = 0;
        ref_victim = 0;
        ref_hits   = 0;
        ref_miss   = 0;
        ref_evict  = 0;
        check_stats();
        lookup(32'hCAFE0001, 1'b1, 0);
        lookup(32'hCAFE0001, 1'b1, 0);
        lookup(32'hCAFE0002, 1'b1, 0);
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
